// File: rtl/axis_instr_packer.sv
// axis_instr_packer: serializes opcode/payload commands into MSB-first byte-wide AXI-stream instruction words
// Ports: clk/rst (sync, active-high); cmd_* command handshake (RUN counts split into MAX_RUN chunks);
//        m_axis_* byte stream with tlast on the final byte of each word; busy high outside IDLE.
module axis_instr_packer #(
  parameter int OPC_WIDTH = 2,
  parameter int PLD_WIDTH = 14,
  parameter logic [OPC_WIDTH-1:0] RUN_OPC = 2'b01,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [OPC_WIDTH-1:0] cmd_opc,
  input  logic [PLD_WIDTH-1:0] cmd_pld,
  input  logic [CNT_WIDTH-1:0] cmd_run_cnt,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 busy
);
  localparam int W = OPC_WIDTH + PLD_WIDTH;
  localparam int NB = (W + 7) / 8;
  localparam int PAD = 8 * NB - W;
  localparam int SW = 8 * NB;
  localparam int IW = NB > 1 ? $clog2(NB) : 1;
  localparam logic [CNT_WIDTH-1:0] MAX_RUN = CNT_WIDTH'({PLD_WIDTH{1'b1}});
  typedef enum logic {IDLE, SEND} state_t;
  state_t               state_q, state_d;
  logic [SW-1:0]        sh_q, sh_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [CNT_WIDTH-1:0] rem_q, rem_d;
  logic [CNT_WIDTH-1:0] cnt_src, chunk;
  logic [SW-1:0]        run_word;
  logic                 hs_cmd, hs_out, last;
  // The same min() feeds both the first chunk (from the command) and every reload (from rem).
  assign cnt_src  = state_q == IDLE ? cmd_run_cnt : rem_q;
  assign chunk    = cnt_src > MAX_RUN ? MAX_RUN : cnt_src;
  assign run_word = SW'({RUN_OPC, chunk[PLD_WIDTH-1:0]}) << PAD;
  assign hs_cmd   = cmd_valid && cmd_ready;
  assign hs_out   = m_axis_tvalid && m_axis_tready;
  assign last     = idx_q == IW'(NB - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      idx_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
    end
  end
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    if (state_q == IDLE && hs_cmd) begin
      if (cmd_opc != RUN_OPC) begin
        sh_d    = SW'({cmd_opc, cmd_pld}) << PAD;
        idx_d   = '0;
        state_d = SEND;
      end else if (cmd_run_cnt != '0) begin
        sh_d    = run_word;
        rem_d   = cmd_run_cnt - chunk;
        idx_d   = '0;
        state_d = SEND;
      end
    end else if (state_q == SEND && hs_out) begin
      if (!last) begin
        sh_d  = sh_q << 8;
        idx_d = idx_q + IW'(1);
      end else if (rem_q != '0) begin
        sh_d  = run_word;
        rem_d = rem_q - chunk;
        idx_d = '0;
      end else begin
        state_d = IDLE;
      end
    end
  end
  always_comb begin
    cmd_ready     = state_q == IDLE && !rst;
    m_axis_tvalid = state_q == SEND;
    m_axis_tdata  = sh_q[SW-1 -: 8];
    m_axis_tlast  = state_q == SEND && last;
    busy          = state_q != IDLE;
  end
endmodule

// File: tb/tb_axis_instr_packer.sv
// tb_axis_instr_packer: randomized and directed checks of axis_instr_packer against a queue-based word model
module tb_axis_instr_packer;
  logic        clk = 0;
  logic        rst = 1;
  logic        cmd_valid = 0;
  logic        cmd_ready;
  logic [1:0]  cmd_opc = 0;
  logic [13:0] cmd_pld = 0;
  logic [31:0] cmd_run_cnt = 0;
  logic [7:0]  tdata;
  logic        tvalid, tlast, busy;
  logic        tready = 1;
  logic        v9 = 0, rdy9, tvalid9, tlast9, busy9;
  logic [1:0]  opc9 = 0;
  logic [8:0]  pld9 = 0;
  logic [31:0] cnt9 = 0;
  logic [7:0]  tdata9;
  int          n_cmp = 0, n_err = 0;
  bit          bp = 0;
  logic [8:0]  exp_q[$], obs_q[$];
  always #5 clk = ~clk;
  axis_instr_packer u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opc(cmd_opc),
    .cmd_pld(cmd_pld), .cmd_run_cnt(cmd_run_cnt), .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
    .m_axis_tready(tready), .m_axis_tlast(tlast), .busy(busy)
  );
  axis_instr_packer #(.PLD_WIDTH(9)) u_dut9 (
    .clk(clk), .rst(rst), .cmd_valid(v9), .cmd_ready(rdy9), .cmd_opc(opc9),
    .cmd_pld(pld9), .cmd_run_cnt(cnt9), .m_axis_tdata(tdata9), .m_axis_tvalid(tvalid9),
    .m_axis_tready(1'b1), .m_axis_tlast(tlast9), .busy(busy9)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  // Instruction word: opcode above the field, left-aligned in 16 bits with zero padding below.
  function automatic logic [15:0] mk_word(input int opc, input int fld, input int pw);
    return 16'(((opc << pw) | fld) << (14 - pw));
  endfunction
  task automatic push_word(input logic [15:0] w);
    exp_q.push_back({1'b0, w[15:8]});
    exp_q.push_back({1'b1, w[7:0]});
  endtask
  task automatic build_exp(input int opc, input int pld, input longint cnt);
    longint rem, c;
    exp_q.delete();
    if (opc != 1) push_word(mk_word(opc, pld, 14));
    else begin
      rem = cnt;
      while (rem > 0) begin
        c = rem > 16383 ? 16383 : rem;
        push_word(mk_word(1, int'(c), 14));
        rem -= c;
      end
    end
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    tready = bp ? ($urandom_range(0, 99) < 30) : 1'b1;
  end
  // Stream monitor: records every handshake and checks hold-while-stalled behaviour.
  initial begin
    bit         prev_stall = 0;
    logic [8:0] prev = 0;
    forever begin
      @(negedge clk);
      if (rst) prev_stall = 0;
      else begin
        if (prev_stall) begin
          chk("stall_valid", tvalid, 1);
          chk("stall_data", tdata, prev[7:0]);
          chk("stall_last", tlast, prev[8]);
        end
        if (tvalid) chk("ready_in_send", cmd_ready, 0);
        if (tvalid && tready) obs_q.push_back({tlast, tdata});
        prev_stall = tvalid && !tready;
        prev = {tlast, tdata};
      end
    end
  end
  task automatic run_cmd(input logic [1:0] opc, input logic [13:0] pld, input logic [31:0] cnt, input bit wait_done);
    bit acc = 0, done = 0;
    build_exp(opc, pld, cnt);
    obs_q.delete();
    @(posedge clk);
    #1;
    cmd_valid = 1;
    cmd_opc = opc;
    cmd_pld = pld;
    cmd_run_cnt = cnt;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = cmd_ready;
    end
    chk("accept", acc, 1);
    @(posedge clk);
    #1;
    cmd_valid = 0;
    cmd_opc = 2'($urandom);
    cmd_pld = 14'($urandom);
    cmd_run_cnt = $urandom;
    @(negedge clk);
    chk("latency_valid", tvalid, exp_q.size() != 0);
    chk("latency_busy", busy, exp_q.size() != 0);
    if (wait_done) begin
      for (int i = 0; i < 4000 && !done; i++) begin
        if (!busy) done = 1;
        else begin
          @(negedge clk);
          #1;
        end
      end
      chk("done_timeout", done, 1);
      chk("nbytes", obs_q.size(), exp_q.size());
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) chk($sformatf("byte%0d", i), obs_q[i], exp_q[i]);
    end
  endtask
  initial begin
    logic [15:0] w;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cmd_ready, 0);
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("idle_ready", cmd_ready, 1);
    run_cmd(2'b10, 14'h0005, 0, 1);
    run_cmd(2'b01, 0, 20000, 1);
    run_cmd(2'b01, 0, 0, 1);
    run_cmd(2'b01, 0, 16383, 1);
    run_cmd(2'b01, 0, 16384, 1);
    bp = 1;
    run_cmd(2'b01, 0, 20000, 1);
    bp = 0;
    @(posedge clk);
    #1;
    v9 = 1;
    opc9 = 2'b11;
    pld9 = 9'h1FF;
    @(negedge clk);
    chk("w9_ready", rdy9, 1);
    @(posedge clk);
    #1;
    v9 = 0;
    w = mk_word(3, 511, 9);
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      chk("w9_valid", tvalid9, 1);
      chk($sformatf("w9_byte%0d", b), tdata9, b == 0 ? w[15:8] : w[7:0]);
      chk("w9_last", tlast9, b == 1);
    end
    @(negedge clk);
    chk("w9_idle", busy9, 0);
    run_cmd(2'b01, 0, 20000, 0);
    for (int i = 0; i < 200 && obs_q.size() < 3; i++) begin
      @(negedge clk);
      #1;
    end
    chk("abort_seen", obs_q.size(), 3);
    @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_tvalid", tvalid, 0);
    chk("abort_busy", busy, 0);
    for (int i = 0; i < 3 && i < obs_q.size(); i++) chk($sformatf("abort_byte%0d", i), obs_q[i], exp_q[i]);
    @(posedge clk);
    #1;
    rst = 0;
    run_cmd(2'b10, 14'h0001, 0, 1);
    for (int k = 0; k < 24; k++) begin
      logic [1:0]  o = 2'($urandom);
      logic [13:0] p = 14'($urandom);
      logic [31:0] c = $urandom_range(0, 3) == 0 ? $urandom_range(0, 3) : $urandom_range(0, 16383 * 6);
      bp = $urandom_range(0, 1) == 1;
      run_cmd(o, p, c, 1);
    end
    bp = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
